// File: rtl/window_shift_buffer_pkg.sv
// rtl/window_shift_buffer_pkg.sv - shared types and default sizes for the window shift buffer
package window_shift_buffer_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_WIN_LEN = 8;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/window_shift_buffer_if.sv
// rtl/window_shift_buffer_if.sv - sample input stream and window output stream bundle
interface window_shift_buffer_if
  import window_shift_buffer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WIN_LEN = DEF_WIN_LEN
) ();

  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W*WIN_LEN-1:0] windowdata;
  logic [15:0]               window_index;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, windowdata, window_index
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, windowdata, window_index
  );

endinterface

// File: rtl/window_shift_buffer.sv
// rtl/window_shift_buffer.sv - sliding sample window with fill/stream FSM and one-deep output register
module window_shift_buffer
  import window_shift_buffer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int STRIDE  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  window_shift_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] STRIDE_LAST = CNT_W'(STRIDE - 1);

  state_t                    state;
  logic [CNT_W-1:0]          fill_cnt;
  logic [CNT_W-1:0]          stride_cnt;
  logic [DATA_W*WIN_LEN-1:0] slots;
  logic [DATA_W*WIN_LEN-1:0] shifted;
  logic [DATA_W*WIN_LEN-1:0] windowdata_q;
  logic                      out_valid_q;
  logic [15:0]               window_index_q;
  logic [15:0]               emit_cnt;
  logic                      in_ready_c;
  logic                      accept;
  logic                      emit;

  // A pending window blocks input unless it drains in this same cycle.
  assign in_ready_c = !clear && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  always_comb begin
    shifted = '0;
    shifted[DATA_W-1:0] = bus.in_data;
    for (int k = 1; k < WIN_LEN; k++) begin
      shifted[DATA_W*k +: DATA_W] = slots[DATA_W*(k-1) +: DATA_W];
    end
  end

  // stride_cnt holds accepts since the last emit; the STRIDE-th one emits.
  assign emit = accept &&
                (((state == ST_FILL)   && (fill_cnt   == FILL_LAST)) ||
                 ((state == ST_STREAM) && (stride_cnt == STRIDE_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_FILL;
      fill_cnt       <= '0;
      stride_cnt     <= '0;
      slots          <= '0;
      windowdata_q   <= '0;
      out_valid_q    <= 1'b0;
      window_index_q <= '0;
      emit_cnt       <= '0;
    end else if (clear) begin
      state          <= ST_FILL;
      fill_cnt       <= '0;
      stride_cnt     <= '0;
      slots          <= '0;
      windowdata_q   <= '0;
      out_valid_q    <= 1'b0;
      window_index_q <= '0;
      emit_cnt       <= '0;
    end else begin
      if (accept) begin
        slots <= shifted;
        case (state)
          ST_FILL: begin
            fill_cnt <= fill_cnt + CNT_W'(1);
            if (fill_cnt == FILL_LAST) begin
              state      <= ST_STREAM;
              stride_cnt <= '0;
            end
          end
          ST_STREAM: begin
            stride_cnt <= (stride_cnt == STRIDE_LAST) ? '0 : stride_cnt + CNT_W'(1);
          end
          default: state <= ST_FILL;
        endcase
      end

      if (emit) begin
        out_valid_q    <= 1'b1;
        windowdata_q   <= shifted;
        window_index_q <= emit_cnt;
        emit_cnt       <= emit_cnt + 16'd1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.windowdata   = windowdata_q;
  assign bus.window_index = window_index_q;

endmodule

// File: tb/tb_window_shift_buffer.sv
// tb/tb_window_shift_buffer.sv - directed self-checking bench for window_shift_buffer
module tb_window_shift_buffer;

  logic clk;
  logic rst_n;
  logic clear_a;
  logic clear_b;
  int   total;
  int   bad;

  window_shift_buffer_if #(.DATA_W(32), .WIN_LEN(8)) a_if ();
  window_shift_buffer_if #(.DATA_W(32), .WIN_LEN(8)) b_if ();

  window_shift_buffer #(.DATA_W(32), .WIN_LEN(8), .STRIDE(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_a),
    .bus   (a_if.slave)
  );

  window_shift_buffer #(.DATA_W(32), .WIN_LEN(8), .STRIDE(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_b),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] slot(input logic [255:0] w, input int k);
    return w[32*k +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b1;
    repeat (3) tick();
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", a_if.out_valid); end
    total++; if (a_if.windowdata !== 256'd0) begin bad++; $display("FAIL reset_windowdata got=%0h exp=0", a_if.windowdata); end
    total++; if (a_if.window_index !== 16'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", a_if.window_index); end
    rst_n = 1'b1;
    #1;
    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", a_if.in_ready); end
    total++; if (b_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_b got=%0b exp=1", b_if.in_ready); end
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] sum;
    a_if.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_if.in_valid = 1'b1; a_if.in_data = 32'(i);
      tick();
      if (i < 8) begin
        total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL fill_early_valid i=%0d got=%0b exp=0", i, a_if.out_valid); end
      end
    end
    a_if.in_valid = 1'b0;
    total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL fill_valid got=%0b exp=1", a_if.out_valid); end
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      total++; if (slot(a_if.windowdata, k) !== 32'(8 - k)) begin bad++; $display("FAIL fill_slot%0d got=%0d exp=%0d", k, slot(a_if.windowdata, k), 8 - k); end
      sum = sum + slot(a_if.windowdata, k);
    end
    total++; if (sum !== 32'd36) begin bad++; $display("FAIL fill_sum got=%0d exp=36", sum); end
    total++; if (a_if.window_index !== 16'd0) begin bad++; $display("FAIL fill_index got=%0d exp=0", a_if.window_index); end
    tick();
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL fill_drain got=%0b exp=0", a_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 9; i <= 11; i++) begin
      a_if.in_valid = 1'b1; a_if.in_data = 32'(i);
      tick();
      total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid i=%0d got=%0b exp=1", i, a_if.out_valid); end
      total++; if (slot(a_if.windowdata, 0) !== 32'(i)) begin bad++; $display("FAIL b2b_slot0 got=%0d exp=%0d", slot(a_if.windowdata, 0), i); end
      total++; if (slot(a_if.windowdata, 7) !== 32'(i - 7)) begin bad++; $display("FAIL b2b_slot7 got=%0d exp=%0d", slot(a_if.windowdata, 7), i - 7); end
      total++; if (a_if.window_index !== 16'(i - 8)) begin bad++; $display("FAIL b2b_index got=%0d exp=%0d", a_if.window_index, i - 8); end
    end
    a_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    a_if.out_ready = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_data = 32'd12;
    tick();
    a_if.in_data = 32'd13;
    for (int c = 0; c < 10; c++) begin
      total++; if (a_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%0b exp=0", c, a_if.in_ready); end
      total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%0b exp=1", c, a_if.out_valid); end
      total++; if (slot(a_if.windowdata, 0) !== 32'd12 || slot(a_if.windowdata, 1) !== 32'd11) begin bad++; $display("FAIL bp_data c=%0d got=%0h exp=12/11", c, a_if.windowdata[63:0]); end
      total++; if (a_if.window_index !== 16'd4) begin bad++; $display("FAIL bp_index c=%0d got=%0d exp=4", c, a_if.window_index); end
      tick();
    end
    a_if.out_ready = 1'b1;
    #1;
    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b exp=1", a_if.in_ready); end
    tick();
    a_if.in_valid = 1'b0;
    total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL bp_pass_valid got=%0b exp=1", a_if.out_valid); end
    total++; if (slot(a_if.windowdata, 0) !== 32'd13) begin bad++; $display("FAIL bp_pass_slot0 got=%0d exp=13", slot(a_if.windowdata, 0)); end
    total++; if (a_if.window_index !== 16'd5) begin bad++; $display("FAIL bp_pass_index got=%0d exp=5", a_if.window_index); end
    tick();
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", a_if.out_valid); end
  endtask

  task automatic test_signed();
    logic [31:0] vals [3];
    vals[0] = 32'h8000_0000; vals[1] = 32'hFFFF_FFFF; vals[2] = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      a_if.in_valid = 1'b1; a_if.in_data = vals[i];
      tick();
    end
    a_if.in_valid = 1'b0;
    total++; if (slot(a_if.windowdata, 0) !== 32'h7FFF_FFFF) begin bad++; $display("FAIL signed_slot0 got=%0h exp=7fffffff", slot(a_if.windowdata, 0)); end
    total++; if (slot(a_if.windowdata, 1) !== 32'hFFFF_FFFF) begin bad++; $display("FAIL signed_slot1 got=%0h exp=ffffffff", slot(a_if.windowdata, 1)); end
    total++; if (slot(a_if.windowdata, 2) !== 32'h8000_0000) begin bad++; $display("FAIL signed_slot2 got=%0h exp=80000000", slot(a_if.windowdata, 2)); end
    total++; if (slot(a_if.windowdata, 3) !== 32'd13) begin bad++; $display("FAIL signed_slot3 got=%0h exp=d", slot(a_if.windowdata, 3)); end
    total++; if (a_if.window_index !== 16'd8) begin bad++; $display("FAIL signed_index got=%0d exp=8", a_if.window_index); end
    tick();
  endtask

  task automatic test_clear();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    total++; if (a_if.windowdata !== 256'd0 || a_if.out_valid !== 1'b0) begin bad++; $display("FAIL clear_outputs got=%0b/%0h exp=0/0", a_if.out_valid, a_if.windowdata); end
    total++; if (a_if.window_index !== 16'd0) begin bad++; $display("FAIL clear_index got=%0d exp=0", a_if.window_index); end
    for (int i = 21; i <= 25; i++) begin
      a_if.in_valid = 1'b1; a_if.in_data = 32'(i);
      tick();
    end
    clear_a = 1'b1; a_if.in_data = 32'd99;
    #1;
    total++; if (a_if.in_ready !== 1'b0) begin bad++; $display("FAIL clear_in_ready got=%0b exp=0", a_if.in_ready); end
    tick();
    clear_a = 1'b0;
    for (int i = 31; i <= 38; i++) begin
      a_if.in_data = 32'(i);
      tick();
      if (i < 38) begin
        total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL clear_refill_early i=%0d got=%0b exp=0", i, a_if.out_valid); end
      end
    end
    a_if.in_valid = 1'b0;
    total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL clear_refill_valid got=%0b exp=1", a_if.out_valid); end
    total++; if (slot(a_if.windowdata, 0) !== 32'd38 || slot(a_if.windowdata, 7) !== 32'd31) begin bad++; $display("FAIL clear_refill_data got=%0d/%0d exp=38/31", slot(a_if.windowdata, 0), slot(a_if.windowdata, 7)); end
    total++; if (a_if.window_index !== 16'd0) begin bad++; $display("FAIL clear_refill_index got=%0d exp=0", a_if.window_index); end
    tick();
  endtask

  task automatic test_stride();
    int  wins;
    logic exp_v;
    wins = 0;
    b_if.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      b_if.in_valid = 1'b1; b_if.in_data = 32'(i);
      tick();
      exp_v = (i >= 8) && (i % 4 == 0);
      total++; if (b_if.out_valid !== exp_v) begin bad++; $display("FAIL stride_valid i=%0d got=%0b exp=%0b", i, b_if.out_valid, exp_v); end
      if (exp_v) begin
        total++; if (slot(b_if.windowdata, 0) !== 32'(i)) begin bad++; $display("FAIL stride_slot0 got=%0d exp=%0d", slot(b_if.windowdata, 0), i); end
        total++; if (b_if.window_index !== 16'((i - 8) / 4)) begin bad++; $display("FAIL stride_index got=%0d exp=%0d", b_if.window_index, (i - 8) / 4); end
      end
      if (b_if.out_valid === 1'b1) wins++;
    end
    b_if.in_valid = 1'b0;
    tick();
    total++; if (wins !== 3) begin bad++; $display("FAIL stride_count got=%0d exp=3", wins); end
  endtask

  task automatic test_async_reset();
    a_if.out_ready = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_data = 32'd40;
    tick();
    a_if.in_valid = 1'b0;
    total++; if (a_if.out_valid !== 1'b1 || a_if.window_index !== 16'd1) begin bad++; $display("FAIL arst_pre got=%0b/%0d exp=1/1", a_if.out_valid, a_if.window_index); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", a_if.out_valid); end
    total++; if (a_if.windowdata !== 256'd0) begin bad++; $display("FAIL arst_data got=%0h exp=0", a_if.windowdata); end
    tick();
    rst_n = 1'b1;
    a_if.out_ready = 1'b1;
    for (int i = 51; i <= 58; i++) begin
      a_if.in_valid = 1'b1; a_if.in_data = 32'(i);
      tick();
      if (i < 58) begin
        total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL arst_refill_early i=%0d got=%0b exp=0", i, a_if.out_valid); end
      end
    end
    a_if.in_valid = 1'b0;
    total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL arst_refill_valid got=%0b exp=1", a_if.out_valid); end
    total++; if (slot(a_if.windowdata, 0) !== 32'd58 || slot(a_if.windowdata, 7) !== 32'd51) begin bad++; $display("FAIL arst_refill_data got=%0d/%0d exp=58/51", slot(a_if.windowdata, 0), slot(a_if.windowdata, 7)); end
    total++; if (a_if.window_index !== 16'd0) begin bad++; $display("FAIL arst_refill_index got=%0d exp=0", a_if.window_index); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_signed();
    test_clear();
    test_stride();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
